// File: rtl/simon_pkg.sv
// Types shared by the sequence player and its pattern memory: color index,
// FSM state encoding, default depth and the color-to-LED decode.
package simon_pkg;
  localparam int DEPTH_DEF = 16;

  typedef logic [1:0] color_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  function automatic logic [3:0] onehot(input color_t c);
    return 4'b0001 << c;
  endfunction
endpackage

// File: rtl/sequence_player_if.sv
// Control, pattern-write and display signals of the sequence player.
interface sequence_player_if #(parameter int DEPTH = simon_pkg::DEPTH_DEF) ();
  import simon_pkg::*;
  localparam int AW = $clog2(DEPTH);

  logic          tick;
  logic          start;
  logic [AW:0]   length;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  color_t        wr_data;
  logic [3:0]    led;
  logic          busy;
  logic          done;
  logic [AW-1:0] step;

  modport master (output tick, start, length, wr_en, wr_addr, wr_data,
                  input  led, busy, done, step);
  modport slave  (input  tick, start, length, wr_en, wr_addr, wr_data,
                  output led, busy, done, step);
endinterface

// File: rtl/pattern_ram.sv
// Color pattern storage: one synchronous write port, asynchronous read, no reset.
module pattern_ram
  import simon_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  color_t        wdata,
  input  logic [AW-1:0] raddr,
  output color_t        rdata
);
  color_t mem [DEPTH];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  assign rdata = mem[raddr];
endmodule

// File: rtl/sequence_player.sv
// Plays the stored color pattern: each entry lit for ON_TICKS ticks, then dark
// for GAP_TICKS ticks, followed by a one-cycle done pulse.
module sequence_player
  import simon_pkg::*;
#(
  parameter int DEPTH     = DEPTH_DEF,
  parameter int ON_TICKS  = 2,
  parameter int GAP_TICKS = 1
) (
  input logic              clk,
  input logic              reset,
  sequence_player_if.slave bus
);
  localparam int AW   = $clog2(DEPTH);
  localparam int LW   = AW + 1;
  localparam int TMAX = (ON_TICKS > GAP_TICKS) ? ON_TICKS : GAP_TICKS;
  localparam int CW   = $clog2(TMAX + 1);
  localparam logic [CW-1:0] ON_LAST  = CW'(ON_TICKS - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_TICKS - 1);
  localparam logic [LW-1:0] DEPTH_L  = LW'(DEPTH);

  state_t        state, state_n;
  logic [AW-1:0] idx, idx_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [LW-1:0] len, len_n;
  logic [3:0]    led_q, led_n;
  logic          busy_q, busy_n, done_q, done_n;
  logic [AW-1:0] step_q, step_n;
  color_t        rd_color;

  pattern_ram #(.DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .we    (bus.wr_en && (state == S_IDLE)),
    .waddr (bus.wr_addr),
    .wdata (bus.wr_data),
    .raddr (idx),
    .rdata (rd_color)
  );

  always_comb begin
    state_n = state;
    idx_n   = idx;
    cnt_n   = cnt;
    len_n   = len;
    case (state)
      S_IDLE: if (bus.start) begin
        idx_n = '0;
        cnt_n = '0;
        if (bus.length == '0) begin
          len_n   = '0;
          state_n = S_DONE;
        end else begin
          len_n   = (bus.length > DEPTH_L) ? DEPTH_L : bus.length;
          state_n = S_ON;
        end
      end
      S_ON: if (bus.tick) begin
        if (cnt == ON_LAST) begin
          cnt_n   = '0;
          state_n = S_GAP;
        end else cnt_n = cnt + CW'(1);
      end
      S_GAP: if (bus.tick) begin
        if (cnt == GAP_LAST) begin
          cnt_n = '0;
          if ({1'b0, idx} == len - LW'(1)) state_n = S_DONE;
          else begin
            idx_n   = idx + AW'(1);
            state_n = S_ON;
          end
        end else cnt_n = cnt + CW'(1);
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase

    // LED follows the registered index, so it lights one cycle after ON is
    // entered; this also lets a same-cycle write land before it is read.
    led_n  = (state == S_ON && state_n == S_ON) ? onehot(rd_color) : 4'b0000;
    busy_n = (state_n == S_ON) || (state_n == S_GAP);
    step_n = busy_n ? idx_n : '0;
    done_n = (state_n == S_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      idx    <= '0;
      cnt    <= '0;
      len    <= '0;
      led_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      step_q <= '0;
    end else begin
      state  <= state_n;
      idx    <= idx_n;
      cnt    <= cnt_n;
      len    <= len_n;
      led_q  <= led_n;
      busy_q <= busy_n;
      done_q <= done_n;
      step_q <= step_n;
    end
  end

  assign bus.led  = led_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.step = step_q;
endmodule

// File: doc/sequence_player.md
SEQUENCE_PLAYER -- requirements
Module: sequence_player

Interface
REQ-001 Parameter DEPTH, default 16, pattern memory entries (power of two).
REQ-002 Parameter ON_TICKS, default 2, ticks each color stays lit (>=1).
REQ-003 Parameter GAP_TICKS, default 1, dark ticks after each color (>=1).
REQ-004 clk  input  1  single system clock; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-high; clears all state.
REQ-006 tick  input  1  one-cycle pacing strobe from the clock divider.
REQ-007 start  input  1  one-cycle request to play the stored pattern.
REQ-008 length  input  $clog2(DEPTH)+1  number of entries to play, sampled on accepted start.
REQ-009 wr_en  input  1  pattern write strobe.
REQ-010 wr_addr  input  $clog2(DEPTH)  pattern write address.
REQ-011 wr_data  input  2  color index written (0..3).
REQ-012 led  output  4  one-hot lit color, 0 when dark.
REQ-013 busy  output  1  high in ON and GAP states.
REQ-014 done  output  1  one-cycle pulse at playback completion.
REQ-015 step  output  $clog2(DEPTH)  index of entry currently playing.

Function
REQ-016 States: IDLE, ON, GAP, DONE; led, busy, done, step are registered.
REQ-017 IDLE: start with length>0 -> ON, index=0, tick counter=0; length latched, values above DEPTH clamped to DEPTH.
REQ-018 IDLE: start with length==0 -> DONE directly; no LED activity.
REQ-019 ON: led=onehot(mem[index]) starting the cycle after entry; each tick increments counter; tick with counter==ON_TICKS-1 -> GAP, counter=0.
REQ-020 GAP: led=0; tick with counter==GAP_TICKS-1 -> DONE if index==length-1, else index+1 and ON.
REQ-021 DONE: done=1 for exactly one cycle, led=0, -> IDLE.
REQ-022 Only tick advances counters; cycles without tick hold state.
REQ-023 A tick coincident with accepted start is not counted.
REQ-024 start while busy or in DONE is ignored.
REQ-025 wr_en writes mem[wr_addr]=wr_data in IDLE only; ignored otherwise.
REQ-026 Write and start in the same IDLE cycle: write takes effect, playback reads updated memory.
REQ-027 Playback duration for length N equals N*(ON_TICKS+GAP_TICKS) ticks.
REQ-028 step equals index in ON/GAP, 0 otherwise.

Reset
REQ-029 reset asserted -> IDLE, led=0, busy=0, done=0, step=0, counters=0, latched length=0, immediately and asynchronously.
REQ-030 Pattern memory contents are not cleared by reset.
REQ-031 reset mid-playback aborts with no done pulse; next start plays from index 0.

Structure
REQ-032 Shared package simon_pkg holds the 2-bit color type, state encoding, and DEPTH default.
REQ-033 Memory is sub-module pattern_ram: one write port, asynchronous read port, no reset.
REQ-034 FSM, counters and one-hot decode live in sequence_player.

Verification
REQ-035 Write {0,3,1} at addr 0..2, start length=3, ticks every 4 cycles -> led 0001,0001,0000,1000,1000,0000,0010,0010,0000 per tick, then done pulse, busy low.
REQ-036 start length=0 -> done high exactly one cycle later for one cycle, led stays 0, busy stays 0.
REQ-037 start length=20 with DEPTH=16 -> 16 entries played, step reaches 15, one done pulse.
REQ-038 Second start and wr_en during playback -> no restart, memory unchanged, step sequence uninterrupted.
REQ-039 reset asserted during GAP of entry 1 -> outputs 0 without waiting for clk edge, no done; fresh start plays from step 0.
REQ-040 tick held 0 for 100 cycles in ON -> led and step constant, no transition.
